// File: rtl/amba3_apb_slave_regs_if.sv
// APB bus bundle between master and the register-bank completer.
// The pslverr wire exists only when AMBA3_APB_SLAVE_REGS_PSLVERR_EN is defined.
interface amba3_apb_slave_regs_if #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
);
  logic [ADDR_SIZE-1:0] paddr;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [DATA_SIZE-1:0] pwdata;
  logic                 pready;
  logic [DATA_SIZE-1:0] prdata;
`ifdef AMBA3_APB_SLAVE_REGS_PSLVERR_EN
  logic                 pslverr;

  modport master (output paddr, psel, penable, pwrite, pwdata,
                  input  pready, prdata, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                  output pready, prdata, pslverr);
`else
  modport master (output paddr, psel, penable, pwrite, pwdata,
                  input  pready, prdata);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                  output pready, prdata);
`endif
endinterface

// File: rtl/amba3_apb_slave_regs.sv
// AMBA 3 APB completer: REG_NUM read/write registers, WAIT_CYCLES wait states per access.
// Define AMBA3_APB_SLAVE_REGS_PSLVERR_EN to flag out-of-range accesses on pslverr.
module amba3_apb_slave_regs #(
  parameter int ADDR_SIZE   = 32,
  parameter int DATA_SIZE   = 32,
  parameter int REG_NUM     = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                         pclk,
  input  logic                         preset,
  amba3_apb_slave_regs_if.slave        apb,
  output logic [REG_NUM*DATA_SIZE-1:0] reg_q,
  output logic [REG_NUM-1:0]           reg_wr
);
  localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_cnt, w_cnt_nxt;
  logic [DATA_SIZE-1:0] r_regs [REG_NUM];
  logic [REG_NUM-1:0]   r_reg_wr;

  logic [IDX_W-1:0]     w_idx;
  logic                 w_in_range;
  logic                 w_ready;
  logic                 w_wr_en;

  // Any address bit above the word index makes the access out of range.
  assign w_idx      = apb.paddr[IDX_W+1:2];
  assign w_in_range = ((apb.paddr >> (IDX_W + 2)) == '0) && (32'(w_idx) < REG_NUM);

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = 8'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          w_state_nxt = IDLE;
        end else if (apb.penable) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 8'd1;
          end else begin
            w_ready     = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_wr_en = w_ready && apb.pwrite && w_in_range;

  // NOTE: the register bank is reset because its cleared state is architecturally visible on reg_q.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
      r_reg_wr <= '0;
    end else begin
      r_reg_wr <= '0;
      if (w_wr_en) begin
        r_regs[w_idx]   <= apb.pwdata;
        r_reg_wr[w_idx] <= 1'b1;
      end
    end
  end

  assign apb.pready = w_ready;
  assign apb.prdata = (w_ready && !apb.pwrite && w_in_range) ? r_regs[w_idx] : '0;
`ifdef AMBA3_APB_SLAVE_REGS_PSLVERR_EN
  assign apb.pslverr = w_ready && !w_in_range;
`endif

  assign reg_wr = r_reg_wr;

  for (genvar g = 0; g < REG_NUM; g++) begin : g_reg_q
    assign reg_q[g*DATA_SIZE +: DATA_SIZE] = r_regs[g];
  end
endmodule

// File: tb/tb_amba3_apb_slave_regs.sv
// Directed bench: two completers (0 and 3 wait states) on separate APB interfaces,
// a vector table of transfers plus hand sequences for missing setup, abort and reset.
module tb_amba3_apb_slave_regs;
  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  amba3_apb_slave_regs_if #(.ADDR_SIZE(32), .DATA_SIZE(32)) if0 ();
  amba3_apb_slave_regs_if #(.ADDR_SIZE(32), .DATA_SIZE(32)) if3 ();

  logic [255:0] rq0, rq3;
  logic [7:0]   rw0, rw3;

  amba3_apb_slave_regs #(.ADDR_SIZE(32), .DATA_SIZE(32), .REG_NUM(8), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .preset(preset), .apb(if0), .reg_q(rq0), .reg_wr(rw0));
  amba3_apb_slave_regs #(.ADDR_SIZE(32), .DATA_SIZE(32), .REG_NUM(8), .WAIT_CYCLES(3)) dut3 (
    .pclk(pclk), .preset(preset), .apb(if3), .reg_q(rq3), .reg_wr(rw3));

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model [2][8];

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_wr;
    bit          exp_err;
  } vec_t;

  vec_t vt [15];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input bit sel, input bit en, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if0.psel    = (d == 0) && sel;
    if3.psel    = (d == 1) && sel;
    if0.penable = en;   if3.penable = en;
    if0.pwrite  = wr;   if3.pwrite  = wr;
    if0.paddr   = addr; if3.paddr   = addr;
    if0.pwdata  = wdata; if3.pwdata = wdata;
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? if0.pready : if3.pready;
  endfunction

  function automatic logic [31:0] rdat(input int d);
    return (d == 0) ? if0.prdata : if3.prdata;
  endfunction

  function automatic logic serr(input int d);
`ifdef AMBA3_APB_SLAVE_REGS_PSLVERR_EN
    return (d == 0) ? if0.pslverr : if3.pslverr;
`else
    return (d < 0);
`endif
  endfunction

  function automatic logic [255:0] pack(input int d);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = model[d][i];
    return v;
  endfunction

  // Entered and left at 1 time unit after a rising edge, so calls chain back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int waits, output logic [7:0] wr_pulse,
                      output logic err, output bit bad_idle);
    bit done;
    done = 1'b0; waits = 0; bad_idle = 1'b0; rdata = '0; err = 1'b0;
    drive(d, 1'b1, 1'b0, wr, addr, wdata);
    @(negedge pclk);
    if (rdy(d) !== 1'b0 || rdat(d) !== 32'h0 || serr(d) !== 1'b0) bad_idle = 1'b1;
    @(posedge pclk); #1;
    drive(d, 1'b1, 1'b1, wr, addr, wdata);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge pclk);
      if (rdy(d) === 1'b1) begin
        done  = 1'b1;
        rdata = rdat(d);
        err   = serr(d);
      end else begin
        waits++;
        if (rdat(d) !== 32'h0 || serr(d) !== 1'b0) bad_idle = 1'b1;
      end
      @(posedge pclk); #1;
    end
    if (!done) check("pready_timeout", 256'd0, 256'd1);
    wr_pulse = (d == 0) ? rw0 : rw3;
    drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    int          waits;
    logic [7:0]  wp;
    logic        err;
    bit          bad;

    vt[0]  = '{0, 1'b1, 32'h08,       32'hDEADBEEF, 32'h0,        8'h04, 1'b0};
    vt[1]  = '{0, 1'b0, 32'h08,       32'h0,        32'hDEADBEEF, 8'h00, 1'b0};
    vt[2]  = '{0, 1'b1, 32'h0B,       32'hA5A5A5A5, 32'h0,        8'h04, 1'b0};
    vt[3]  = '{0, 1'b0, 32'h08,       32'h0,        32'hA5A5A5A5, 8'h00, 1'b0};
    vt[4]  = '{0, 1'b1, 32'h20,       32'hFFFFFFFF, 32'h0,        8'h00, 1'b1};
    vt[5]  = '{0, 1'b0, 32'h20,       32'h0,        32'h0,        8'h00, 1'b1};
    vt[6]  = '{0, 1'b1, 32'h80000004, 32'h11111111, 32'h0,        8'h00, 1'b1};
    vt[7]  = '{0, 1'b1, 32'h00,       32'hAAAA0000, 32'h0,        8'h01, 1'b0};
    vt[8]  = '{0, 1'b1, 32'h04,       32'hBBBB0004, 32'h0,        8'h02, 1'b0};
    vt[9]  = '{0, 1'b1, 32'h1C,       32'hCCCC001C, 32'h0,        8'h80, 1'b0};
    vt[10] = '{0, 1'b0, 32'h1C,       32'h0,        32'hCCCC001C, 8'h00, 1'b0};
    vt[11] = '{0, 1'b0, 32'h04,       32'h0,        32'hBBBB0004, 8'h00, 1'b0};
    vt[12] = '{1, 1'b1, 32'h04,       32'h12345678, 32'h0,        8'h02, 1'b0};
    vt[13] = '{1, 1'b0, 32'h04,       32'h0,        32'h12345678, 8'h00, 1'b0};
    vt[14] = '{1, 1'b0, 32'h24,       32'h0,        32'h0,        8'h00, 1'b1};

    for (int d = 0; d < 2; d++) for (int i = 0; i < 8; i++) model[d][i] = '0;

    preset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("reset_reg_q0", rq0, 256'd0);
    check("reset_reg_q3", rq3, 256'd0);
    check("reset_reg_wr", {rw3, rw0}, 256'd0);
    check("reset_pready", {if3.pready, if0.pready}, 256'd0);
    check("reset_prdata", {if3.prdata, if0.prdata}, 256'd0);
    @(posedge pclk); #1;

    for (int v = 0; v < 15; v++) begin
      xfer(vt[v].d, vt[v].wr, vt[v].addr, vt[v].wdata, rdata, waits, wp, err, bad);
      for (int b = 0; b < 8; b++)
        if (vt[v].exp_wr[b]) model[vt[v].d][b] = vt[v].wdata;
      check($sformatf("v%0d_waits", v), 256'(waits), (vt[v].d == 0) ? 256'd0 : 256'd3);
      check($sformatf("v%0d_idle_outputs_zero", v), 256'(bad), 256'd0);
      check($sformatf("v%0d_prdata", v), 256'(rdata), 256'(vt[v].exp_rd));
      check($sformatf("v%0d_reg_wr", v), 256'(wp), 256'(vt[v].exp_wr));
      check($sformatf("v%0d_reg_q", v), (vt[v].d == 0) ? rq0 : rq3, pack(vt[v].d));
`ifdef AMBA3_APB_SLAVE_REGS_PSLVERR_EN
      check($sformatf("v%0d_pslverr", v), 256'(err), 256'(vt[v].exp_err));
`endif
    end

    @(posedge pclk); #1;
    check("reg_wr_single_cycle", {rw3, rw0}, 256'd0);

    // Access phase without setup must be ignored.
    drive(0, 1'b1, 1'b1, 1'b1, 32'h00, 32'h99999999);
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      check($sformatf("nosetup_pready_%0d", c), 256'(if0.pready), 256'd0);
    end
    @(posedge pclk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge pclk); #1;
    check("nosetup_reg_q", rq0, pack(0));

    // Abort: psel dropped during a 3-wait access to 0x0C.
    drive(1, 1'b1, 1'b0, 1'b1, 32'h0C, 32'h77777777);
    @(posedge pclk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h77777777);
    @(posedge pclk); #1;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge pclk); #1;
    check("abort_reg_q", rq3, pack(1));
    check("abort_reg_wr", 256'(rw3), 256'd0);
    xfer(1, 1'b1, 32'h0C, 32'h0C0C0C0C, rdata, waits, wp, err, bad);
    model[1][3] = 32'h0C0C0C0C;
    check("after_abort_waits", 256'(waits), 256'd3);
    check("after_abort_reg_wr", 256'(wp), 256'h08);
    check("after_abort_reg_q", rq3, pack(1));

    // Reset asserted mid-access.
    drive(1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h55555555);
    @(posedge pclk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h55555555);
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) for (int i = 0; i < 8; i++) model[d][i] = '0;
    check("midreset_reg_q0", rq0, 256'd0);
    check("midreset_reg_q3", rq3, 256'd0);
    @(negedge pclk);
    check("midreset_pready", 256'(if3.pready), 256'd0);
    @(posedge pclk); #1;
    xfer(1, 1'b1, 32'h10, 32'h13572468, rdata, waits, wp, err, bad);
    model[1][4] = 32'h13572468;
    check("postreset_waits", 256'(waits), 256'd3);
    check("postreset_reg_wr", 256'(wp), 256'h10);
    xfer(1, 1'b0, 32'h10, 32'h0, rdata, waits, wp, err, bad);
    check("postreset_prdata", 256'(rdata), 256'h13572468);
    check("postreset_reg_q", rq3, pack(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/amba3_apb_slave_regs.md
Name: amba3_apb_slave_regs

Overview:
- Synthesizable AMBA 3 APB 1.0 completer: a bank of REG_NUM read/write registers with a programmable number of wait states.
- Responds to the APB master signalling (paddr, psel, penable, pwrite, pwdata) and drives pready/prdata.
- Serves as the RTL end of the APB link, both as the default DUT for the APB master bench and as a reusable control-register block.
- Exposes register contents and per-register write pulses to user logic.

Parameters:
ADDR_SIZE, 32, paddr width
DATA_SIZE, 32, pwdata/prdata/register width
REG_NUM, 8, number of registers (>=1); word index = paddr[IDX_W+1:2], IDX_W = max(1,$clog2(REG_NUM))
WAIT_CYCLES, 0, wait states inserted in every access phase (0..255)

Ports:
pclk  input  1  clock, all logic on rising edge
preset  input  1  synchronous active-high reset
paddr  input  ADDR_SIZE  byte address; bits [1:0] ignored
psel  input  1  slave select
penable  input  1  access phase
pwrite  input  1  1=write, 0=read
pwdata  input  DATA_SIZE  write data
pready  output  1  transfer completes this cycle
prdata  output  DATA_SIZE  read data, valid when pready & !pwrite
reg_q  output  REG_NUM*DATA_SIZE  register contents, reg i at [i*DATA_SIZE +: DATA_SIZE]
reg_wr  output  REG_NUM  one-cycle pulse: reg i written at the last edge

Behaviour:
- Reset (preset=1 at an edge): state=IDLE, wait counter=0, all registers=0, reg_wr=0. pready=0 and prdata=0 from the following cycle onward.
- FSM states are IDLE and ACCESS.
- IDLE -> ACCESS: on psel=1 & penable=0 (setup phase). Counter loads WAIT_CYCLES.
- ACCESS, psel=1 & penable=1 & cnt!=0: decrement cnt; pready=0.
- ACCESS, psel=1 & penable=1 & cnt==0: pready=1 (combinational from state/cnt). The transfer completes at this edge; next state is IDLE.
- ACCESS, psel=0: abort (protocol violation). Return to IDLE; no write, no reg_wr.
- Transfer length is 2+WAIT_CYCLES cycles, setup cycle included.
- Back-to-back transfers: the master's next setup cycle follows completion, and IDLE accepts it immediately. No dead cycle is required.
- Write: on the completing edge, if idx<REG_NUM then reg[idx]<=pwdata and reg_wr[idx]=1 for the next cycle. Otherwise the write is ignored.
- Read: prdata = reg[idx] when pready=1 & pwrite=0 & idx<REG_NUM. prdata=0 otherwise, including out-of-range reads and all non-ready cycles.
- Out of range: word index >= REG_NUM, or any paddr bit above IDX_W+1 set.
- paddr/pwrite/pwdata are sampled at the completing edge. The master holds them stable through the access phase per APB.
- pready is never 1 in IDLE. A psel=1 & penable=1 seen in IDLE (missing setup) is ignored until a proper setup phase.
- Reset mid-transfer: the transfer is dropped, no register update, and pready=0 next cycle.
- Registers hold their value when not written. reg_wr has at most one bit set.

Optional Feature:
- Macro: AMBA3_APB_SLAVE_REGS_PSLVERR_EN.
- Defined: adds output port pslverr (1 bit, reset 0). pslverr=1 only when pready=1 and the access is out of range; it is 0 in all other cycles. Out-of-range writes are still discarded and reads still return 0.
- Not defined: no pslverr port; out-of-range accesses complete silently.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to paddr 0x08, then read 0x08 -> pready high in 2nd cycle of each transfer; prdata=0xDEADBEEF; reg_wr=8'b0000_0100 for one cycle; reg_q[2]=0xDEADBEEF.
- WAIT_CYCLES=3: read 0x04 after writing 0x12345678 -> pready low for 3 access cycles, then high in cycle 5; prdata=0x12345678; prdata=0 in non-ready cycles.
- Out-of-range: write 0xFFFFFFFF to 0x20 (REG_NUM=8), then read 0x20 -> no reg_wr, all reg_q unchanged; prdata=0. With the macro defined, pslverr=1 in the completing cycle only.
- Back-to-back: writes to 0x00, 0x04, 0x1C in consecutive transfers (no idle cycles) -> all three registers updated; reg_wr pulses 0x01, 0x02, 0x80 on successive completions.
- Abort/reset: deassert psel during a 3-wait access to 0x0C -> reg[3] unchanged, FSM in IDLE. Assert preset mid-access -> all reg_q=0 and pready=0 next cycle; the subsequent normal transfer succeeds.
- Unaligned: write 0xA5A5A5A5 to paddr 0x0B -> treated as 0x08; reg_q[2]=0xA5A5A5A5.
